// File: rtl/dds_spi_cmd_master_pkg.sv
// DDS SPI command framing constants and helpers.
// Shared with the DDS receiving side.
package dds_spi_pkg;

  localparam logic [7:0] CMD_FREQ = 8'h01;
  localparam logic [7:0] CMD_ENV  = 8'h02;

  localparam logic [1:0] FREQ_FRAME_BYTES = 2'd3;
  localparam logic [1:0] ENV_FRAME_BYTES  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  // Byte 0 is always the command id; FREQ sends the high byte before the low.
  function automatic logic [7:0] frame_byte(
    input logic [7:0]  id,
    input logic [15:0] data,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    b = data[7:0];
    if (idx == 2'd0) b = id;
    else if (idx == 2'd1 && id == CMD_FREQ) b = data[15:8];
    return b;
  endfunction

endpackage

// File: rtl/dds_spi_cmd_master_if.sv
// Host command handshake bundle for the DDS SPI master.
// Host drives valid/id/data; the master returns ready/busy/error.
interface dds_spi_cmd_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_data;
  logic        busy;
  logic        err_bad_cmd;

  modport master (
    output cmd_valid,
    output cmd_id,
    output cmd_data,
    input  cmd_ready,
    input  busy,
    input  err_bad_cmd
  );

  modport slave (
    input  cmd_valid,
    input  cmd_id,
    input  cmd_data,
    output cmd_ready,
    output busy,
    output err_bad_cmd
  );

endinterface

// File: rtl/dds_spi_cmd_master_shift.sv
// SPI mode-0 byte shifter: sclk divider, MSB-first TX, MISO RX.
// byte_end flags the falling edge that closes the 8th bit.
module dds_spi_cmd_master_shift
  import dds_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_end,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int DW = cnt_width(CLK_DIV, 1, 1, 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;

  always_comb begin
    div_d      = div_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_d       = tx_q;
    rx_sr_d    = rx_sr_q;
    bit_d      = bit_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    byte_end   = 1'b0;
    if (en) begin
      if (div_q == DW'(CLK_DIV - 1)) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], miso};
          if (bit_q == 3'd7) begin
            rx_byte_d  = {rx_sr_q[6:0], miso};
            rx_valid_d = 1'b1;
          end
        end else begin
          sclk_d   = 1'b0;
          bit_d    = bit_q + 3'd1;
          byte_end = (bit_q == 3'd7);
          mosi_d   = tx_q[7];
          tx_d     = {tx_q[6:0], 1'b0};
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    // A load on the closing edge presents the next byte's MSB at once.
    if (load) begin
      mosi_d = load_byte[7];
      tx_d   = {load_byte[6:0], 1'b0};
      bit_d  = '0;
      div_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_q      <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_q       <= '0;
      rx_sr_q    <= '0;
      bit_q      <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_q       <= tx_d;
      rx_sr_q    <= rx_sr_d;
      bit_q      <= bit_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: rtl/dds_spi_cmd_master.sv
// SPI master framing FREQ/ENV commands to the wavetable DDS slave.
// FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
module dds_spi_cmd_master
  import dds_spi_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int INTER_FRAME = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  dds_spi_cmd_master_if.slave  cmd,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  output logic                 spi_nss,
  input  logic                 spi_miso,
  output logic [7:0]           rx_byte,
  output logic                 rx_valid
);

  localparam int CW = cnt_width(
    CLK_DIV, CS_SETUP, CS_HOLD, INTER_FRAME);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    byte_q, byte_d;
  logic [1:0]    nbytes_q, nbytes_d;
  logic [7:0]    id_q, id_d;
  logic [15:0]   data_q, data_d;
  logic          nss_q, nss_d;
  logic          err_q, err_d;

  logic       load;
  logic [7:0] load_byte;
  logic       byte_end;
  logic       id_ok;

  assign id_ok = (cmd.cmd_id == CMD_FREQ)
              || (cmd.cmd_id == CMD_ENV);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    nbytes_d  = nbytes_q;
    id_d      = id_q;
    data_d    = data_q;
    nss_d     = nss_q;
    err_d     = 1'b0;
    load      = 1'b0;
    load_byte = frame_byte(id_q, data_q, byte_q + 2'd1);
    unique case (state_q)
      IDLE: begin
        nss_d = 1'b1;
        if (cmd.cmd_valid && id_ok) begin
          state_d   = SETUP;
          nss_d     = 1'b0;
          cnt_d     = '0;
          byte_d    = '0;
          id_d      = cmd.cmd_id;
          data_d    = cmd.cmd_data;
          nbytes_d  = (cmd.cmd_id == CMD_FREQ)
                    ? FREQ_FRAME_BYTES : ENV_FRAME_BYTES;
          load      = 1'b1;
          load_byte = cmd.cmd_id;
        end else if (cmd.cmd_valid) begin
          err_d = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (byte_end) begin
          if (byte_q == nbytes_q - 2'd1) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            byte_d = byte_q + 2'd1;
            load   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          state_d = GAP;
          nss_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(INTER_FRAME - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      nbytes_q <= '0;
      id_q     <= '0;
      data_q   <= '0;
      nss_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      nbytes_q <= nbytes_d;
      id_q     <= id_d;
      data_q   <= data_d;
      nss_q    <= nss_d;
      err_q    <= err_d;
    end
  end

  dds_spi_cmd_master_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk       (clk),
    .nreset    (nreset),
    .en        (state_q == SHIFT),
    .load      (load),
    .load_byte (load_byte),
    .miso      (spi_miso),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .byte_end  (byte_end),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid)
  );

  assign spi_nss         = nss_q;
  assign cmd.cmd_ready   = (state_q == IDLE);
  assign cmd.busy        = (state_q != IDLE);
  assign cmd.err_bad_cmd = err_q;

endmodule

// File: tb/tb_dds_spi_cmd_master.sv
// Directed bench for dds_spi_cmd_master.
// Frames are reconstructed from the SPI pins on every clk fall.
module tb_dds_spi_cmd_master;

  logic       clk;
  logic       nreset;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_nss;
  logic       spi_miso;
  logic [7:0] rx_byte;
  logic       rx_valid;

  int checks = 0;
  int fails  = 0;

  dds_spi_cmd_master_if bus ();

  dds_spi_cmd_master dut (
    .clk      (clk),
    .nreset   (nreset),
    .cmd      (bus.slave),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_nss  (spi_nss),
    .spi_miso (spi_miso),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0]  id,
                          input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = id;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.cmd_ready) begin
      fails++;
      $display("FAIL send_cmd: ready timeout got 0 expected 1");
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic capture_frame(
    input  logic [23:0] miso_pat,
    input  bit          drop_valid,
    output logic [23:0] bits,
    output int          nrise,
    output int          nlow,
    output int          nhigh,
    output int          nrx,
    output logic [7:0]  rx0,
    output logic [7:0]  rx1,
    output bit          align_ok
  );
    logic prev;
    bit   seen;
    bits = '0; nrise = 0; nlow = 0; nhigh = 0;
    nrx = 0; rx0 = '0; rx1 = '0; align_ok = 1;
    seen = 0; prev = 1'b0;
    spi_miso = miso_pat[23];
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (!spi_nss) begin
        if (!seen && drop_valid) bus.cmd_valid = 1'b0;
        seen = 1;
        nlow++;
      end else if (seen) begin
        break;
      end else begin
        nhigh++;
      end
      if (spi_sclk && !prev) begin
        bits = {bits[22:0], spi_mosi};
        nrise++;
      end
      prev = spi_sclk;
      if (rx_valid) begin
        if (nrx == 0) rx0 = rx_byte;
        else rx1 = rx_byte;
        nrx++;
        if (nrise % 8 != 0) align_ok = 0;
      end
      spi_miso = (nrise < 24) ? miso_pat[23-nrise] : 1'b0;
    end
    spi_miso = 1'b0;
    chk("frame_done", {31'd0, seen && spi_nss}, 32'd1);
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_id = '0;
    bus.cmd_data = '0;
    spi_miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_nss", {31'd0, spi_nss}, 32'd1);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err_bad_cmd}, 32'd0);
    chk("rst_rxv", {31'd0, rx_valid}, 32'd0);
    chk("rst_rxb", {24'd0, rx_byte}, 32'd0);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_freq;
    logic [23:0] b; logic [7:0] r0, r1;
    int nr, nl, nh, nx; bit al;
    send_cmd(8'h01, 16'h1234);
    chk("freq_busy", {31'd0, bus.busy}, 32'd1);
    capture_frame(24'h0, 1, b, nr, nl, nh, nx, r0, r1, al);
    chk("freq_bits", {8'd0, b}, 32'h011234);
    chk("freq_rises", nr, 32'd24);
    chk("freq_nss_low", nl, 32'd196);
  endtask

  task automatic test_env;
    logic [23:0] b; logic [7:0] r0, r1;
    int nr, nl, nh, nx; bit al;
    send_cmd(8'h02, 16'h0080);
    capture_frame(24'h0, 1, b, nr, nl, nh, nx, r0, r1, al);
    chk("env_bits", {16'd0, b[15:0]}, 32'h0280);
    chk("env_rises", nr, 32'd16);
    chk("env_nss_low", nl, 32'd132);
  endtask

  task automatic test_bad_cmd;
    int errs, first;
    bit nss_seen, sclk_seen, not_rdy;
    errs = 0; first = -1;
    nss_seen = 0; sclk_seen = 0; not_rdy = 0;
    repeat (20) @(negedge clk);
    send_cmd(8'h07, 16'hFFFF);
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.err_bad_cmd) begin
        if (first < 0) first = t;
        errs++;
      end
      if (!spi_nss) nss_seen = 1;
      if (spi_sclk) sclk_seen = 1;
      if (!bus.cmd_ready) not_rdy = 1;
    end
    chk("bad_err_count", errs, 32'd1);
    chk("bad_err_when", first, 32'd0);
    chk("bad_no_nss", {31'd0, nss_seen}, 32'd0);
    chk("bad_no_sclk", {31'd0, sclk_seen}, 32'd0);
    chk("bad_ready", {31'd0, not_rdy}, 32'd0);
  endtask

  task automatic test_back_to_back;
    logic [23:0] b; logic [7:0] r0, r1;
    int nr, nl, nh, nx; bit al;
    send_cmd(8'h01, 16'h5A0F);
    bus.cmd_id    = 8'h01;
    bus.cmd_data  = 16'hABCD;
    bus.cmd_valid = 1'b1;
    capture_frame(24'h0, 0, b, nr, nl, nh, nx, r0, r1, al);
    chk("b2b_bits0", {8'd0, b}, 32'h015A0F);
    chk("b2b_low0", nl, 32'd196);
    capture_frame(24'h0, 1, b, nr, nl, nh, nx, r0, r1, al);
    checks++;
    if (nh + 1 < 8) begin
      fails++;
      $display("FAIL b2b_gap: got %0d expected >= 8", nh + 1);
    end
    chk("b2b_bits1", {8'd0, b}, 32'h01ABCD);
    chk("b2b_rises1", nr, 32'd24);
    chk("b2b_low1", nl, 32'd196);
  endtask

  task automatic test_miso_rx;
    logic [23:0] b; logic [7:0] r0, r1;
    int nr, nl, nh, nx; bit al;
    send_cmd(8'h02, 16'h0080);
    capture_frame(24'hA53C00, 1, b, nr, nl, nh, nx, r0, r1, al);
    chk("rx_count", nx, 32'd2);
    chk("rx_byte0", {24'd0, r0}, 32'hA5);
    chk("rx_byte1", {24'd0, r1}, 32'h3C);
    chk("rx_align", {31'd0, al}, 32'd1);
    chk("rx_env_bits", {16'd0, b[15:0]}, 32'h0280);
  endtask

  task automatic test_reset_mid_frame;
    logic [23:0] b; logic [7:0] r0, r1;
    int nr, nl, nh, nx; bit al;
    logic prev;
    int rises;
    prev = 1'b0; rises = 0;
    send_cmd(8'h01, 16'hBEEF);
    for (int t = 0; t < 2000 && rises < 12; t++) begin
      @(negedge clk);
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
    end
    chk("mid_reached", rises, 32'd12);
    chk("mid_nss_low", {31'd0, spi_nss}, 32'd0);
    @(posedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("mid_nss", {31'd0, spi_nss}, 32'd1);
    chk("mid_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rxb", {24'd0, rx_byte}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("mid_ready", {31'd0, bus.cmd_ready}, 32'd1);
    send_cmd(8'h02, 16'h005A);
    capture_frame(24'h0, 1, b, nr, nl, nh, nx, r0, r1, al);
    chk("mid_env_bits", {16'd0, b[15:0]}, 32'h025A);
    chk("mid_env_rises", nr, 32'd16);
    chk("mid_env_low", nl, 32'd132);
  endtask

  initial begin
    test_reset();
    test_freq();
    test_env();
    test_bad_cmd();
    test_back_to_back();
    test_miso_rx();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
